// File: rtl/exc_ctrl.sv
// Exception/interrupt controller for the single-cycle LEGv8 core: one synchronous
// exception plus NSRC maskable interrupt lines, fixed priority, ELR/ESR capture, ERET.
module exc_ctrl #(
    parameter int              N      = 64,
    parameter int              NSRC   = 4,
    parameter int              ESW    = 4,
    parameter logic [N-1:0]    EVADDR = 'hD8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sync_exc,
    input  logic [ESW-1:0]    sync_status,
    input  logic [NSRC-1:0]   irq,
    input  logic [NSRC-1:0]   irq_mask,
    input  logic              eret,
    input  logic [N-1:0]      cur_pc,
    input  logic [N-1:0]      next_pc,
    input  logic [N-1:0]      imem_addr,
    output logic              eproc,
    output logic [N-1:0]      evaddr,
    output logic              exc_ack,
    output logic              ret_valid,
    output logic [N-1:0]      ret_pc,
    output logic [N-1:0]      elr,
    output logic [ESW-1:0]    esr,
    output logic              in_handler,
    output logic [NSRC-1:0]   pending,
    output logic              double_fault
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        REDIRECT = 3'd1,
        HANDLER  = 3'd2,
        RETURN   = 3'd3,
        FAULT    = 3'd4
    } state_t;

    state_t            state, state_nxt;
    logic [NSRC-1:0]   irq_prev;
    logic [NSRC-1:0]   eligible;
    logic [NSRC-1:0]   irq_clr;
    logic [ESW-1:0]    irq_idx;
    logic              irq_hit;
    logic              take_sync, take_irq;

    // Lowest-index eligible line wins: scan downward so the last hit is the smallest index.
    always_comb begin
        eligible = pending & ~irq_mask;
        irq_hit  = 1'b0;
        irq_idx  = '0;
        irq_clr  = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                irq_hit = 1'b1;
                irq_idx = ESW'(i);
                irq_clr = NSRC'(1) << i;
            end
        end
    end

    assign exc_ack = (state == REDIRECT) && (imem_addr == EVADDR);

    always_comb begin
        state_nxt = state;
        take_sync = 1'b0;
        take_irq  = 1'b0;
        case (state)
            IDLE: begin
                if (sync_exc) begin
                    take_sync = 1'b1;
                    state_nxt = REDIRECT;
                end else if (irq_hit) begin
                    take_irq  = 1'b1;
                    state_nxt = REDIRECT;
                end
            end
            REDIRECT: if (exc_ack) state_nxt = HANDLER;
            HANDLER: begin
                if (eret)          state_nxt = RETURN;
                else if (sync_exc) state_nxt = FAULT;
            end
            RETURN:  state_nxt = IDLE;
            FAULT:   state_nxt = FAULT;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_prev     <= '0;
            pending      <= '0;
            elr          <= '0;
            esr          <= '0;
            double_fault <= 1'b0;
        end else begin
            irq_prev <= irq;
            // A new edge on the line being taken re-arms it (set beats clear).
            pending  <= (pending & ~(take_irq ? irq_clr : '0)) | (irq & ~irq_prev);
            if (take_sync) begin
                elr <= cur_pc;
                esr <= sync_status;
            end else if (take_irq) begin
                elr <= next_pc;
                esr <= ESW'(2 ** (ESW - 1)) + irq_idx;
            end
            if (state == HANDLER && sync_exc && !eret)
                double_fault <= 1'b1;
        end
    end

    assign eproc      = (state == REDIRECT);
    assign ret_valid  = (state == RETURN);
    assign in_handler = (state == HANDLER);
    assign ret_pc     = elr;
    assign evaddr     = EVADDR;

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed bench for exc_ctrl: reset, sync/irq takes, priority, masking, ERET, double fault.
module tb_exc_ctrl;
    localparam int N = 64, NSRC = 4, ESW = 4;

    logic            clk = 0, reset = 1;
    logic            sync_exc = 0, eret = 0;
    logic [ESW-1:0]  sync_status = 0;
    logic [NSRC-1:0] irq = 0, irq_mask = 0;
    logic [N-1:0]    cur_pc = 0, next_pc = 0, imem_addr = 0;
    logic            eproc, exc_ack, ret_valid, in_handler, double_fault;
    logic [N-1:0]    evaddr, ret_pc, elr;
    logic [ESW-1:0]  esr;
    logic [NSRC-1:0] pending;

    int n_chk = 0, n_fail = 0;

    exc_ctrl #(.N(N), .NSRC(NSRC), .ESW(ESW), .EVADDR(64'hD8)) dut (
        .clk(clk), .reset(reset), .sync_exc(sync_exc), .sync_status(sync_status),
        .irq(irq), .irq_mask(irq_mask), .eret(eret), .cur_pc(cur_pc),
        .next_pc(next_pc), .imem_addr(imem_addr), .eproc(eproc), .evaddr(evaddr),
        .exc_ack(exc_ack), .ret_valid(ret_valid), .ret_pc(ret_pc), .elr(elr),
        .esr(esr), .in_handler(in_handler), .pending(pending),
        .double_fault(double_fault)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic enter_handler();
        imem_addr = 64'hD8; tick(); imem_addr = 0;
    endtask

    task automatic leave_handler();
        eret = 1; tick(); eret = 0; tick();
    endtask

    task automatic test_reset();
        reset = 1; #12;
        n_chk++; if (eproc !== 0) begin n_fail++; $display("FAIL reset_eproc got %0h exp 0", eproc); end
        n_chk++; if (evaddr !== 64'hD8) begin n_fail++; $display("FAIL reset_evaddr got %0h exp d8", evaddr); end
        n_chk++; if ({exc_ack, ret_valid, in_handler, double_fault, pending, esr} !== '0 || elr !== 0) begin
            n_fail++; $display("FAIL reset_outputs got ack=%0b rv=%0b ih=%0b df=%0b pend=%0h esr=%0h elr=%0h exp all 0",
                               exc_ack, ret_valid, in_handler, double_fault, pending, esr, elr); end
        @(negedge clk); reset = 0; tick();
    endtask

    task automatic test_sync();
        sync_exc = 1; sync_status = 4'h3; cur_pc = 64'h40; tick(); sync_exc = 0;
        n_chk++; if (eproc !== 1) begin n_fail++; $display("FAIL sync_eproc got %0b exp 1", eproc); end
        n_chk++; if (elr !== 64'h40) begin n_fail++; $display("FAIL sync_elr got %0h exp 40", elr); end
        n_chk++; if (esr !== 4'h3) begin n_fail++; $display("FAIL sync_esr got %0h exp 3", esr); end
        n_chk++; if (exc_ack !== 0) begin n_fail++; $display("FAIL sync_ack_early got %0b exp 0", exc_ack); end
        tick();
        n_chk++; if (eproc !== 1 || in_handler !== 0) begin n_fail++; $display("FAIL sync_hold_redirect got eproc=%0b ih=%0b exp 1/0", eproc, in_handler); end
        imem_addr = 64'hD8; #1;
        n_chk++; if (exc_ack !== 1) begin n_fail++; $display("FAIL sync_ack got %0b exp 1", exc_ack); end
        tick(); imem_addr = 0;
        n_chk++; if (in_handler !== 1 || eproc !== 0) begin n_fail++; $display("FAIL sync_handler got ih=%0b eproc=%0b exp 1/0", in_handler, eproc); end
        eret = 1; tick(); eret = 0;
        n_chk++; if (ret_valid !== 1 || ret_pc !== 64'h40) begin n_fail++; $display("FAIL sync_ret got rv=%0b pc=%0h exp 1/40", ret_valid, ret_pc); end
        tick();
        n_chk++; if (ret_valid !== 0 || in_handler !== 0 || eproc !== 0) begin n_fail++; $display("FAIL sync_idle got rv=%0b ih=%0b ep=%0b exp 0", ret_valid, in_handler, eproc); end
    endtask

    task automatic test_irq();
        irq = 4'b0110; next_pc = 64'h100; tick();
        n_chk++; if (pending !== 4'b0110 || eproc !== 0) begin n_fail++; $display("FAIL irq_latch got pend=%0h ep=%0b exp 6/0", pending, eproc); end
        tick();
        n_chk++; if (eproc !== 1 || esr !== 4'h9) begin n_fail++; $display("FAIL irq1_take got ep=%0b esr=%0h exp 1/9", eproc, esr); end
        n_chk++; if (elr !== 64'h100 || pending !== 4'b0100) begin n_fail++; $display("FAIL irq1_state got elr=%0h pend=%0h exp 100/4", elr, pending); end
        enter_handler();
        n_chk++; if (in_handler !== 1 || pending !== 4'b0100) begin n_fail++; $display("FAIL irq_no_nest got ih=%0b pend=%0h exp 1/4", in_handler, pending); end
        eret = 1; tick(); eret = 0; next_pc = 64'h200;
        n_chk++; if (ret_valid !== 1 || ret_pc !== 64'h100) begin n_fail++; $display("FAIL irq_ret got rv=%0b pc=%0h exp 1/100", ret_valid, ret_pc); end
        tick();
        n_chk++; if (eproc !== 0 || ret_valid !== 0) begin n_fail++; $display("FAIL irq_idle_gap got ep=%0b rv=%0b exp 0/0", eproc, ret_valid); end
        tick();
        n_chk++; if (eproc !== 1 || esr !== 4'hA || elr !== 64'h200 || pending !== 0) begin
            n_fail++; $display("FAIL irq2_take got ep=%0b esr=%0h elr=%0h pend=%0h exp 1/a/200/0", eproc, esr, elr, pending); end
        enter_handler(); leave_handler();
        irq = 0; tick();
    endtask

    task automatic test_eret_idle();
        eret = 1; tick(); eret = 0;
        n_chk++; if (ret_valid !== 0 || eproc !== 0 || in_handler !== 0 || elr !== 64'h200) begin
            n_fail++; $display("FAIL eret_idle got rv=%0b ep=%0b ih=%0b elr=%0h exp 0/0/0/200", ret_valid, eproc, in_handler, elr); end
    endtask

    task automatic test_sync_vs_irq();
        cur_pc = 64'h80; next_pc = 64'h84;
        sync_exc = 1; sync_status = 4'h5; irq = 4'b0001; tick(); sync_exc = 0;
        n_chk++; if (esr !== 4'h5 || elr !== 64'h80 || pending !== 4'b0001) begin
            n_fail++; $display("FAIL prio_sync got esr=%0h elr=%0h pend=%0h exp 5/80/1", esr, elr, pending); end
        enter_handler(); leave_handler(); tick();
        n_chk++; if (eproc !== 1 || esr !== 4'h8 || elr !== 64'h84 || pending !== 0) begin
            n_fail++; $display("FAIL prio_irq0 got ep=%0b esr=%0h elr=%0h pend=%0h exp 1/8/84/0", eproc, esr, elr, pending); end
        enter_handler(); leave_handler();
    endtask

    task automatic test_mask();
        irq_mask = 4'b1000; irq = 4'b1000; tick(); tick(); tick();
        n_chk++; if (pending !== 4'b1000 || eproc !== 0) begin n_fail++; $display("FAIL mask_hold got pend=%0h ep=%0b exp 8/0", pending, eproc); end
        irq_mask = 0; tick();
        n_chk++; if (eproc !== 1 || esr !== 4'hB || pending !== 0) begin n_fail++; $display("FAIL mask_take got ep=%0b esr=%0h pend=%0h exp 1/b/0", eproc, esr, pending); end
        enter_handler(); leave_handler();
        irq = 0; tick();
    endtask

    task automatic test_double_fault();
        sync_status = 4'h1; sync_exc = 1; tick(); sync_exc = 0; enter_handler();
        eret = 1; sync_exc = 1; tick(); eret = 0; sync_exc = 0;
        n_chk++; if (ret_valid !== 1 || double_fault !== 0) begin n_fail++; $display("FAIL eret_wins got rv=%0b df=%0b exp 1/0", ret_valid, double_fault); end
        tick();
        sync_exc = 1; tick(); sync_exc = 0; enter_handler();
        sync_exc = 1; tick(); sync_exc = 0;
        n_chk++; if (double_fault !== 1 || eproc !== 0 || in_handler !== 0) begin
            n_fail++; $display("FAIL dfault got df=%0b ep=%0b ih=%0b exp 1/0/0", double_fault, eproc, in_handler); end
        eret = 1; tick(); eret = 0; tick();
        n_chk++; if (double_fault !== 1 || ret_valid !== 0 || eproc !== 0) begin
            n_fail++; $display("FAIL dfault_sticky got df=%0b rv=%0b ep=%0b exp 1/0/0", double_fault, ret_valid, eproc); end
        #3 reset = 1; #1;
        n_chk++; if (double_fault !== 0 || elr !== 0 || esr !== 0) begin
            n_fail++; $display("FAIL async_reset got df=%0b elr=%0h esr=%0h exp 0", double_fault, elr, esr); end
        @(negedge clk); reset = 0; tick();
    endtask

    task automatic test_reset_redirect();
        irq = 4'b0100; irq_mask = 4'b0100; tick();
        sync_exc = 1; tick(); sync_exc = 0;
        n_chk++; if (eproc !== 1 || pending !== 4'b0100) begin n_fail++; $display("FAIL pre_reset got ep=%0b pend=%0h exp 1/4", eproc, pending); end
        #2 reset = 1; #1;
        n_chk++; if (eproc !== 0 || pending !== 0) begin n_fail++; $display("FAIL reset_redirect got ep=%0b pend=%0h exp 0/0", eproc, pending); end
        irq = 0; irq_mask = 0;
        @(negedge clk); reset = 0; tick();
    endtask

    initial begin
        test_reset();
        test_sync();
        test_irq();
        test_eret_idle();
        test_sync_vs_irq();
        test_mask();
        test_double_fault();
        test_reset_redirect();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
